quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 54 +++++
 rtl/quad_filt.sv | 78 +++++++
 rtl/quad_decoder.sv | 132 +++++++++++++
 tb/tb_quad_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature decoder.
//   phase_e      : 2-bit phase {a,b}, named in Gray order of an up rotation
//   step_e       : classification of a phase change
//   DIR_UP/DIR_DN: values driven on the decoder's down output
//   phase_step() : maps (previous phase, new phase) to a step kind
// -----------------------------------------------------------------------------
package quad_pkg;

  typedef enum logic [1:0] {
    PH00 = 2'b00,
    PH01 = 2'b01,
    PH11 = 2'b11,
    PH10 = 2'b10
  } phase_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Up rotation is 00 -> 01 -> 11 -> 10 -> 00. Any change of both bits at
  // once cannot be attributed to a direction and is reported as illegal.
  function automatic step_e phase_step(input phase_e prev, input phase_e curr);
    logic [1:0] prev_bits;
    logic [1:0] curr_bits;
    phase_e     fwd;
    prev_bits = prev;
    curr_bits = curr;
    case (prev)
      PH00:    fwd = PH01;
      PH01:    fwd = PH11;
      PH11:    fwd = PH10;
      default: fwd = PH00;
    endcase
    if (curr_bits == prev_bits) begin
      return STEP_NONE;
    end
    if ((curr_bits ^ prev_bits) == 2'b11) begin
      return STEP_ILL;
    end
    if (curr == fwd) begin
      return STEP_UP;
    end
    return STEP_DN;
  endfunction

endpackage

// File: rtl/quad_filt.sv
// -----------------------------------------------------------------------------
// quad_filt
// One quadrature channel: multi-flop synchronizer followed by a debounce
// filter that accepts a new level only after it has been stable for FILT_LEN
// consecutive cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_raw    : raw channel input, asynchronous to clk
//   i_load   : load the filtered value straight from the synchronizer
//   i_en     : filter enable; while low the stability counter is held clear
//   o_sync   : synchronized (unfiltered) level
//   o_filt   : filtered level
// -----------------------------------------------------------------------------
module quad_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_load,
  input  logic i_en,
  output logic o_sync,
  output logic o_filt
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sync;
  logic                   w_diff;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign w_sync_d[gi] = i_raw;
      end else begin : g_rest
        assign w_sync_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= w_sync_d;
      if (i_load) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else if (i_en && w_diff) begin
        // The count reaching FILT_LEN-1 while still differing means this is
        // the FILT_LEN-th consecutive differing cycle.
        if (r_cnt == CW'(FILT_LEN - 1)) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_sync = w_sync;
  assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Quadrature decoder: synchronizes and debounces channels A/B, tracks the
// phase {a,b} and emits one-cycle step pulses with a direction flag for a
// downstream up/down counter. Illegal (double-bit) phase jumps set a sticky
// error flag.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   qa, qb  : quadrature channels, asynchronous to clk
//   run     : gates en; steps seen while low are dropped
//   clr_err : synchronous clear of err (an illegal jump in the same cycle wins)
//   en      : one-cycle step pulse
//   down    : direction of the last valid step (1 = down)
//   err     : sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic qa,
  input  logic qb,
  input  logic run,
  input  logic clr_err,
  output logic en,
  output logic down,
  output logic err
);

  localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
  localparam int ICW      = $clog2(INIT_LEN);

  // Bit 1 carries channel A and bit 0 channel B so the pair reads as a phase.
  logic [1:0]     w_raw;
  logic [1:0]     w_sync;
  logic [1:0]     w_filt;
  logic           w_load;
  logic [ICW-1:0] r_init_cnt;
  logic           r_init_done;
  phase_e         w_phase;
  phase_e         r_phase_prev;
  step_e          w_step;
  logic           w_valid;
  logic           r_en;
  logic           r_down;
  logic           r_err;

  assign w_raw = {qa, qb};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      quad_filt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
      ) u_filt (
        .clk   (clk),
        .rst   (rst),
        .i_raw (w_raw[gi]),
        .i_load(w_load),
        .i_en  (r_init_done),
        .o_sync(w_sync[gi]),
        .o_filt(w_filt[gi])
      );
    end
  endgenerate

  // The filtered pair is the phase register; r_phase_prev is its value one
  // cycle earlier, so a step is decoded in the cycle after the phase moves.
  assign w_phase = phase_e'(w_filt);
  assign w_step  = phase_step(r_phase_prev, w_phase);
  assign w_valid = (w_step == STEP_UP) || (w_step == STEP_DN);

  // Init window lets the synchronizers fill before the filters and phase
  // are seeded from the current input levels, so power-up levels never
  // look like a step.
  assign w_load = !r_init_done && (r_init_cnt == ICW'(INIT_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (!r_init_done) begin
      if (w_load) begin
        r_init_done <= 1'b1;
      end else begin
        r_init_cnt <= r_init_cnt + ICW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_prev <= PH00;
    end else if (w_load) begin
      r_phase_prev <= phase_e'(w_sync);
    end else if (r_init_done) begin
      r_phase_prev <= w_phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_init_done) begin
      // The !r_en term guarantees a gap between pulses even if the two
      // channels are accepted on adjacent cycles.
      r_en <= w_valid && run && !r_en;
      if (w_valid) begin
        r_down <= (w_step == STEP_DN) ? DIR_DN : DIR_UP;
      end
      if (w_step == STEP_ILL) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end else begin
      r_en <= 1'b0;
    end
  end

  assign en   = r_en;
  assign down = r_down;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  localparam int SS   = 2;
  localparam int FL   = 4;
  localparam int INIT = SS + FL;
  localparam int LAT  = SS + FL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic qa = 1'b0;
  logic qb = 1'b0;
  logic run = 1'b1;
  logic clr_err = 1'b0;
  logic en;
  logic down;
  logic err;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int en_count = 0;
  int last_en_tick = -100;

  // Reference model state: raw samples since reset release, filtered
  // levels, phase now / one cycle ago, and the expected outputs.
  bit raw_a[$];
  bit raw_b[$];
  bit fa, fb, pa_now, pb_now, pa_old, pb_old;
  bit m_en, m_down, m_err;

  always #5 clk = ~clk;

  quad_decoder #(
    .SYNC_STAGES(SS),
    .FILT_LEN   (FL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .qa     (qa),
    .qb     (qb),
    .run    (run),
    .clr_err(clr_err),
    .en     (en),
    .down   (down),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  // Position of a phase along the up rotation 00,01,11,10.
  function automatic int pidx(bit a, bit b);
    return (a ? 2 : 0) + ((a ^ b) ? 1 : 0);
  endfunction

  // True when the raw level seen by the filter on its last FL looks
  // (raw samples n-SS-FL+1 .. n-SS, 1-based) all equal v.
  function automatic bit held(int ch, int n, bit v);
    for (int k = n - SS - FL + 1; k <= n - SS; k++) begin
      if (ch == 0 && raw_a[k-1] != v) return 1'b0;
      if (ch == 1 && raw_b[k-1] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    raw_a.delete();
    raw_b.delete();
    fa = 0; fb = 0; pa_now = 0; pb_now = 0; pa_old = 0; pb_old = 0;
    m_en = 0; m_down = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int n;
    int d;
    bit valid;
    raw_a.push_back(qa);
    raw_b.push_back(qb);
    n = raw_a.size();
    if (n > INIT) begin
      d = (pidx(pa_now, pb_now) - pidx(pa_old, pb_old) + 4) % 4;
      valid = (d == 1) || (d == 3);
      if (valid) m_down = (d == 3);
      if (d == 2) m_err = 1;
      else if (clr_err) m_err = 0;
      m_en = valid && run && !m_en;
    end else begin
      m_en = 0;
    end
    pa_old = pa_now;
    pb_old = pb_now;
    if (n == INIT) begin
      fa = raw_a[INIT-SS-1];
      fb = raw_b[INIT-SS-1];
      pa_old = fa;
      pb_old = fb;
    end else if (n >= INIT + FL) begin
      if (held(0, n, !fa)) fa = !fa;
      if (held(1, n, !fb)) fb = !fb;
    end
    pa_now = fa;
    pb_now = fb;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    tick_no++;
    chk("outs{en,down,err}", {29'd0, en, down, err}, {29'd0, m_en, m_down, m_err});
    if (en) begin
      en_count++;
      last_en_tick = tick_no;
    end
  endtask

  task automatic move(input bit a, input bit b, input int gap, input int exp_pulses,
                      input bit exp_down, input string tag);
    int c0;
    int t0;
    c0 = en_count;
    t0 = tick_no;
    qa = a;
    qb = b;
    repeat (gap) tick();
    chk({tag, " pulses"}, en_count - c0, exp_pulses);
    if (exp_pulses == 1) begin
      chk({tag, " latency"}, last_en_tick - t0, LAT);
      chk({tag, " down"}, {31'd0, down}, {31'd0, exp_down});
    end
    $display("step %s: qa=%0b qb=%0b run=%0b pulses=%0d down=%0b err=%0b",
             tag, a, b, run, en_count - c0, down, err);
  endtask

  initial begin
    int c0;
    bit ca, cb;
    int act, gap, idx, len;
    model_reset();

    // Reset with both inputs high, then hold them: no step, no error.
    qa = 1; qb = 1; run = 1;
    repeat (3) tick();
    chk("reset outputs", {29'd0, en, down, err}, 32'd0);
    rst = 0;
    repeat (20) tick();
    chk("init no en", en_count, 0);
    chk("init no err", {31'd0, err}, 32'd0);
    $display("init: held 11 for 20 cycles, pulses=%0d err=%0b", en_count, err);

    // 11 -> 10 -> 00 are up steps and bring the phase to 00.
    move(1, 0, 10, 1, 0, "up 11->10");
    move(0, 0, 10, 1, 0, "up 10->00");

    // Full up rotation.
    move(0, 1, 10, 1, 0, "up 00->01");
    move(1, 1, 10, 1, 0, "up 01->11");
    move(1, 0, 10, 1, 0, "up 11->10");
    move(0, 0, 10, 1, 0, "up 10->00");

    // Full down rotation, then one up step.
    move(1, 0, 10, 1, 1, "dn 00->10");
    move(1, 1, 10, 1, 1, "dn 10->11");
    move(0, 1, 10, 1, 1, "dn 11->01");
    move(0, 0, 10, 1, 1, "dn 01->00");
    move(0, 1, 10, 1, 0, "up 00->01");

    // 3-cycle glitch on qa is rejected; a 4-cycle pulse is two steps.
    c0 = en_count;
    qa = 1; repeat (3) tick();
    qa = 0; repeat (12) tick();
    chk("glitch3 pulses", en_count - c0, 0);
    $display("glitch: qa high 3 cycles, pulses=%0d", en_count - c0);
    c0 = en_count;
    qa = 1; repeat (4) tick();
    qa = 0; repeat (12) tick();
    chk("pulse4 pulses", en_count - c0, 2);
    chk("pulse4 last down", {31'd0, down}, 32'd1);
    $display("pulse: qa high 4 cycles, pulses=%0d down=%0b", en_count - c0, down);

    // Illegal jumps and err clear priority.
    move(0, 0, 10, 1, 1, "dn 01->00");
    move(1, 1, 10, 0, 0, "ill 00->11");
    chk("illegal sets err", {31'd0, err}, 32'd1);
    c0 = en_count;
    qa = 0; qb = 0;
    repeat (LAT - 1) tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("set beats clear", {31'd0, err}, 32'd1);
    repeat (5) tick();
    chk("illegal no en", en_count - c0, 0);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("clr_err alone", {31'd0, err}, 32'd0);
    $display("illegal: err after clr_err=%0b", err);

    // Steps with run=0 are dropped but still set the direction.
    run = 0;
    move(0, 1, 10, 0, 0, "up 00->01 norun");
    move(1, 1, 10, 0, 0, "up 01->11 norun");
    chk("norun down updated", {31'd0, down}, 32'd0);
    run = 1;
    move(0, 1, 10, 1, 1, "dn 11->01 run");

    // Reset two cycles after an edge aborts the step.
    c0 = en_count;
    qa = 1;
    tick();
    tick();
    rst = 1;
    model_reset();
    #1;
    chk("reset abort outs", {29'd0, en, down, err}, 32'd0);
    tick();
    tick();
    rst = 0;
    repeat (20) tick();
    chk("reset abort pulses", en_count - c0, 0);
    $display("reset mid-step: pulses=%0d", en_count - c0);

    // Randomized walk checked cycle by cycle against the model.
    ca = qa;
    cb = qb;
    for (int it = 0; it < 250; it++) begin
      act = $urandom_range(0, 19);
      gap = $urandom_range(1, 14);
      if (act < 13) begin
        idx = (pidx(ca, cb) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
        ca = (idx >= 2);
        cb = (idx == 1) || (idx == 2);
        qa = ca; qb = cb;
      end else if (act < 15) begin
        ca = !ca; cb = !cb;
        qa = ca; qb = cb;
      end else if (act < 17) begin
        len = $urandom_range(1, 3);
        if (act == 15) qa = !ca; else qb = !cb;
        repeat (len) tick();
        qa = ca; qb = cb;
      end else if (act < 19) begin
        run = !run;
      end else begin
        rst = 1;
        model_reset();
        #1;
        chk("rand reset outs", {29'd0, en, down, err}, 32'd0);
        tick();
        rst = 0;
      end
      for (int g = 0; g < gap; g++) begin
        clr_err = ($urandom_range(0, 15) == 0);
        tick();
      end
      clr_err = 0;
      $display("rand %0d: act=%0d qa=%0b qb=%0b run=%0b en_total=%0d down=%0b err=%0b",
               it, act, qa, qb, run, en_count, down, err);
    end
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
